cpu_core: RTL and testbench

//  16-bit accumulator CPU: fetches, decodes and executes programs from a single-port 4096x16 word memory.

---
 rtl/cpu_core_if.sv | 21 ++
 rtl/cpu_core.sv | 153 +++++++++++++++
 tb/tb_cpu_core.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_if.sv
// Memory bus between the accumulator CPU (master) and its single-port word memory (slave).
interface cpu_core_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [15:0]           mem_value_i;
  logic [15:0]           mem_value_o;
  logic                  mem_enable_o;
  logic                  mem_wr_en_o;
  logic                  mem_rd_en_o;

  modport master (
    output mem_addr_o, mem_value_o, mem_enable_o, mem_wr_en_o, mem_rd_en_o,
    input  mem_value_i
  );

  modport slave (
    input  mem_addr_o, mem_value_o, mem_enable_o, mem_wr_en_o, mem_rd_en_o,
    output mem_value_i
  );
endinterface

// File: rtl/cpu_core.sv
// 16-bit accumulator CPU sharing one synchronous memory port for fetch and operands.
// FETCH -> DECODE -> (MEM ->) EXEC -> FETCH; HALT is terminal until reset.
module cpu_core #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  cpu_core_if.master  mem,
  output logic        end_program_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3,
                         OP_SUB   = 4'h4, OP_AND  = 4'h5, OP_OR    = 4'h6, OP_XOR = 4'h7,
                         OP_NOT   = 4'h8, OP_LDI  = 4'h9, OP_CMP   = 4'hA, OP_JMP = 4'hB,
                         OP_JZ    = 4'hC, OP_JN   = 4'hD, OP_JC    = 4'hE, OP_SHF = 4'hF;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           ir, acc;
  logic                  z_flag, n_flag, c_flag;

  logic [3:0]  dec_op, ex_op;
  logic [15:0] opnd;
  logic [16:0] sum, diff;
  logic [15:0] res;
  logic        wr_acc, wr_zn, wr_c, c_new, jump;

  assign dec_op = mem.mem_value_i[15:12];
  assign ex_op  = ir[15:12];
  assign opnd   = mem.mem_value_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (dec_op)
          OP_HALT:                                  state_nx = S_HALT;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR, OP_CMP:            state_nx = S_MEM;
          default:                                  state_nx = S_EXEC;
        endcase
      end
      S_MEM:    state_nx = (ex_op == OP_STORE) ? S_FETCH : S_EXEC;
      S_EXEC:   state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Bus outputs; reset gates them off combinationally so the environment owns memory.
  always_comb begin
    mem.mem_addr_o  = '0;
    mem.mem_value_o = '0;
    mem.mem_rd_en_o = 1'b0;
    mem.mem_wr_en_o = 1'b0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          mem.mem_addr_o  = pc;
          mem.mem_rd_en_o = 1'b1;
        end
        S_MEM: begin
          mem.mem_addr_o = ir[ADDR_WIDTH-1:0];
          if (ex_op == OP_STORE) begin
            mem.mem_wr_en_o = 1'b1;
            mem.mem_value_o = acc;
          end else begin
            mem.mem_rd_en_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
    mem.mem_enable_o = mem.mem_rd_en_o | mem.mem_wr_en_o;
  end

  // Execute-stage ALU; diff[16] is the unsigned borrow (ACC < operand).
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, opnd};
    diff   = {1'b0, acc} - {1'b0, opnd};
    res    = acc;
    wr_acc = 1'b0;
    wr_zn  = 1'b0;
    wr_c   = 1'b0;
    c_new  = c_flag;
    jump   = 1'b0;
    case (ex_op)
      OP_LOAD: begin res = opnd;              wr_acc = 1'b1; wr_zn = 1'b1; end
      OP_ADD:  begin res = sum[15:0];  c_new = sum[16];  wr_acc = 1'b1; wr_zn = 1'b1; wr_c = 1'b1; end
      OP_SUB:  begin res = diff[15:0]; c_new = diff[16]; wr_acc = 1'b1; wr_zn = 1'b1; wr_c = 1'b1; end
      OP_AND:  begin res = acc & opnd;        wr_acc = 1'b1; wr_zn = 1'b1; end
      OP_OR:   begin res = acc | opnd;        wr_acc = 1'b1; wr_zn = 1'b1; end
      OP_XOR:  begin res = acc ^ opnd;        wr_acc = 1'b1; wr_zn = 1'b1; end
      OP_NOT:  begin res = ~acc;              wr_acc = 1'b1; wr_zn = 1'b1; end
      OP_LDI:  begin res = {4'h0, ir[11:0]};  wr_acc = 1'b1; wr_zn = 1'b1; end
      OP_CMP:  begin res = diff[15:0]; c_new = diff[16]; wr_zn = 1'b1; wr_c = 1'b1; end
      OP_JMP:  jump = 1'b1;
      OP_JZ:   jump = z_flag;
      OP_JN:   jump = n_flag;
      OP_JC:   jump = c_flag;
      OP_SHF: begin
        if (ir[0]) begin res = {1'b0, acc[15:1]}; c_new = acc[0];  end
        else       begin res = {acc[14:0], 1'b0}; c_new = acc[15]; end
        wr_acc = 1'b1; wr_zn = 1'b1; wr_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc            <= '0;
      ir            <= '0;
      acc           <= '0;
      z_flag        <= 1'b0;
      n_flag        <= 1'b0;
      c_flag        <= 1'b0;
      end_program_o <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          ir <= mem.mem_value_i;
          pc <= pc + ADDR_WIDTH'(1);
          if (dec_op == OP_HALT) end_program_o <= 1'b1;
        end
        S_EXEC: begin
          if (wr_acc) acc <= res;
          if (wr_zn) begin
            z_flag <= (res == 16'h0);
            n_flag <= res[15];
          end
          if (wr_c) c_flag <= c_new;
          if (jump) pc <= ir[ADDR_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: behavioural synchronous memory plus per-scenario tasks.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        end_prog;
  logic        clr = 1'b0;
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] rdata = '0;
  logic [15:0] mem_arr [0:4095];
  int          checks = 0;
  int          failures = 0;

  cpu_core_if #(.ADDR_WIDTH(12)) bus();
  cpu_core #(.ADDR_WIDTH(12)) dut (
    .clk_i(clk), .rst_i(rst), .mem(bus), .end_program_o(end_prog)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= 16'h0;
    end else if (pl_we) begin
      mem_arr[pl_addr] <= pl_data;
    end else if (bus.mem_enable_o && bus.mem_wr_en_o) begin
      mem_arr[bus.mem_addr_o] <= bus.mem_value_o;
    end
    if (bus.mem_enable_o && bus.mem_rd_en_o) rdata <= mem_arr[bus.mem_addr_o];
  end
  assign bus.mem_value_i = rdata;

  task automatic start();
    rst = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic put(input logic [11:0] a, input logic [15:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (end_prog) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic test_reset();
    start();
    put(12'h000, 16'h9005);
    step(2);
    checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.mem_enable_o); end
    checks++; if (bus.mem_rd_en_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_strobes rd=%b wr=%b exp=0", bus.mem_rd_en_o, bus.mem_wr_en_o); end
    checks++; if (bus.mem_addr_o !== 12'h0 || bus.mem_value_o !== 16'h0) begin failures++; $display("FAIL reset_bus addr=%h val=%h exp=0", bus.mem_addr_o, bus.mem_value_o); end
    checks++; if (end_prog !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", end_prog); end
    checks++; if (dut.acc !== 16'h0 || dut.pc !== 12'h0) begin failures++; $display("FAIL reset_regs acc=%h pc=%h exp=0", dut.acc, dut.pc); end
  endtask

  task automatic test_store_halt();
    bit seen = 1'b0;
    start();
    put(12'h000, 16'h9005);
    put(12'h001, 16'h2100);
    put(12'h002, 16'h0000);
    put(12'h100, 16'hABCD);
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== 12'h000 || bus.mem_enable_o !== 1'b1) begin failures++; $display("FAIL first_fetch rd=%b addr=%h exp rd=1 addr=000", bus.mem_rd_en_o, bus.mem_addr_o); end
    for (int e = 1; e <= 8; e++) begin
      step(1);
      if (e == 5) begin
        checks++;
        if (bus.mem_wr_en_o !== 1'b1 || bus.mem_rd_en_o !== 1'b0 || bus.mem_addr_o !== 12'h100 || bus.mem_value_o !== 16'h0005) begin
          failures++; $display("FAIL store_cycle wr=%b rd=%b addr=%h val=%h exp wr=1 rd=0 addr=100 val=0005", bus.mem_wr_en_o, bus.mem_rd_en_o, bus.mem_addr_o, bus.mem_value_o);
        end
      end
      if (e == 7) begin checks++; if (end_prog !== 1'b0) begin failures++; $display("FAIL end_early got=%b exp=0", end_prog); end end
      if (e == 8) begin checks++; if (end_prog !== 1'b1) begin failures++; $display("FAIL end_edge8 got=%b exp=1", end_prog); end end
    end
    checks++; if (mem_arr[12'h100] !== 16'h0005) begin failures++; $display("FAIL store_data got=%h exp=0005", mem_arr[12'h100]); end
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_enable_o !== 1'b0) seen = 1'b1;
      step(1);
    end
    checks++; if (seen !== 1'b0 || end_prog !== 1'b1) begin failures++; $display("FAIL halt_quiet access=%b end=%b exp access=0 end=1", seen, end_prog); end
  endtask

  task automatic test_cmp_jz(input logic [15:0] m, input logic [11:0] exp_addr,
                             input logic exp_z, input logic exp_n, input logic exp_c);
    start();
    put(12'h000, 16'h9007);
    put(12'h001, 16'hA050);
    put(12'h002, 16'hC020);
    put(12'h050, m);
    rst = 1'b0;
    step(10);
    checks++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== exp_addr) begin failures++; $display("FAIL cmp_jz_target rd=%b addr=%h exp addr=%h", bus.mem_rd_en_o, bus.mem_addr_o, exp_addr); end
    checks++; if (dut.acc !== 16'h0007) begin failures++; $display("FAIL cmp_acc_kept got=%h exp=0007", dut.acc); end
    checks++; if ({dut.z_flag, dut.n_flag, dut.c_flag} !== {exp_z, exp_n, exp_c}) begin failures++; $display("FAIL cmp_flags znc=%b%b%b exp=%b%b%b", dut.z_flag, dut.n_flag, dut.c_flag, exp_z, exp_n, exp_c); end
  endtask

  task automatic test_add_carry();
    start();
    put(12'h000, 16'h1050);
    put(12'h001, 16'h3051);
    put(12'h002, 16'hE030);
    put(12'h050, 16'hFFFF);
    put(12'h051, 16'h0001);
    rst = 1'b0;
    step(8);
    checks++; if (dut.acc !== 16'h0000 || dut.z_flag !== 1'b1 || dut.c_flag !== 1'b1 || dut.n_flag !== 1'b0) begin failures++; $display("FAIL add_wrap acc=%h z=%b c=%b n=%b exp acc=0000 z=1 c=1 n=0", dut.acc, dut.z_flag, dut.c_flag, dut.n_flag); end
    step(3);
    checks++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== 12'h030) begin failures++; $display("FAIL jc_taken addr=%h exp=030", bus.mem_addr_o); end
  endtask

  task automatic test_sub_borrow();
    bit ok;
    start();
    put(12'h000, 16'h9003);
    put(12'h001, 16'h4050);
    put(12'h002, 16'h2060);
    put(12'h050, 16'h0005);
    rst = 1'b0;
    step(7);
    checks++; if (dut.acc !== 16'hFFFE || dut.n_flag !== 1'b1 || dut.c_flag !== 1'b1 || dut.z_flag !== 1'b0) begin failures++; $display("FAIL sub_borrow acc=%h n=%b c=%b z=%b exp acc=FFFE n=1 c=1 z=0", dut.acc, dut.n_flag, dut.c_flag, dut.z_flag); end
    wait_halt(40, ok);
    checks++; if (ok !== 1'b1 || mem_arr[12'h060] !== 16'hFFFE) begin failures++; $display("FAIL sub_store halted=%b mem=%h exp halted=1 mem=FFFE", ok, mem_arr[12'h060]); end
  endtask

  task automatic test_logic_shift();
    bit ok;
    start();
    put(12'h000, 16'h90F0);
    put(12'h001, 16'h5050);
    put(12'h002, 16'h6051);
    put(12'h003, 16'h7052);
    put(12'h004, 16'h8000);
    put(12'h005, 16'hF000);
    put(12'h006, 16'hF001);
    put(12'h007, 16'h2060);
    put(12'h050, 16'h00FF);
    put(12'h051, 16'h0F00);
    put(12'h052, 16'h0FFF);
    rst = 1'b0;
    step(21);
    checks++; if (dut.acc !== 16'hFFE0 || dut.c_flag !== 1'b1 || dut.n_flag !== 1'b1) begin failures++; $display("FAIL shl acc=%h c=%b n=%b exp acc=FFE0 c=1 n=1", dut.acc, dut.c_flag, dut.n_flag); end
    wait_halt(40, ok);
    checks++; if (ok !== 1'b1 || mem_arr[12'h060] !== 16'h7FF0) begin failures++; $display("FAIL logic_store halted=%b mem=%h exp halted=1 mem=7FF0", ok, mem_arr[12'h060]); end
    checks++; if ({dut.z_flag, dut.n_flag, dut.c_flag} !== 3'b000) begin failures++; $display("FAIL shr_flags znc=%b%b%b exp=000", dut.z_flag, dut.n_flag, dut.c_flag); end
  endtask

  task automatic test_pc_wrap();
    logic [11:0] last = 12'h0;
    logic [11:0] after_fff = 12'hABC;
    bit          saw_fff = 1'b0;
    bit          ok = 1'b0;
    start();
    put(12'h000, 16'hB010);
    put(12'h010, 16'h9000);
    put(12'h011, 16'h2000);
    put(12'h012, 16'hBFFF);
    put(12'hFFF, 16'h9001);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (end_prog) begin ok = 1'b1; break; end
      if (bus.mem_rd_en_o) begin
        if (saw_fff && after_fff == 12'hABC) after_fff = bus.mem_addr_o;
        if (bus.mem_addr_o == 12'hFFF) saw_fff = 1'b1;
        last = bus.mem_addr_o;
      end
      step(1);
    end
    checks++; if (saw_fff !== 1'b1 || after_fff !== 12'h000) begin failures++; $display("FAIL pc_wrap saw_fff=%b next=%h exp saw=1 next=000", saw_fff, after_fff); end
    checks++; if (ok !== 1'b1 || dut.acc !== 16'h0001 || last !== 12'h000) begin failures++; $display("FAIL wrap_halt halted=%b acc=%h last=%h exp 1/0001/000", ok, dut.acc, last); end
  endtask

  task automatic test_reset_mid_store();
    start();
    put(12'h000, 16'h9005);
    put(12'h001, 16'h2100);
    put(12'h100, 16'h1234);
    rst = 1'b0;
    step(5);
    checks++; if (bus.mem_wr_en_o !== 1'b1) begin failures++; $display("FAIL pre_abort_wr got=%b exp=1", bus.mem_wr_en_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_wr_en_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL abort_wr wr=%b en=%b exp=0", bus.mem_wr_en_o, bus.mem_enable_o); end
    step(2);
    checks++; if (mem_arr[12'h100] !== 16'h1234) begin failures++; $display("FAIL abort_mem got=%h exp=1234", mem_arr[12'h100]); end
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== 12'h000 || dut.acc !== 16'h0) begin failures++; $display("FAIL restart rd=%b addr=%h acc=%h exp rd=1 addr=000 acc=0000", bus.mem_rd_en_o, bus.mem_addr_o, dut.acc); end
  endtask

  initial begin
    test_reset();
    test_store_halt();
    test_cmp_jz(16'h0007, 12'h020, 1'b1, 1'b0, 1'b0);
    test_cmp_jz(16'h0008, 12'h003, 1'b0, 1'b1, 1'b1);
    test_add_carry();
    test_sub_borrow();
    test_logic_shift();
    test_pc_wrap();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
